clint_timer: RTL

CLINT_TIMER -- requirements
Module: clint_timer

---
 rtl/clint_timer_if.sv | 19 +
 rtl/clint_timer.sv | 130 +++++++++++++
 2 files changed

// File: rtl/clint_timer_if.sv
// Bus bundle for the CLINT-style timer: one request per cycle, read data registered.
interface clint_timer_if;
    logic        mem_valid;
    logic        mem_write;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_write, mem_wmask, mem_wdata, mem_addr,
        input  mem_rdata
    );

    modport slave (
        input  mem_valid, mem_write, mem_wmask, mem_wdata, mem_addr,
        output mem_rdata
    );
endinterface

// File: rtl/clint_timer.sv
// Machine timer: 64-bit mtime advanced by a prescaler, 64-bit mtimecmp, level interrupt
// when mtime >= mtimecmp. Memory-mapped with byte-masked writes and one-cycle reads.
module clint_timer #(
    parameter logic [31:0] BASE  = 32'h4400_0000,
    parameter int unsigned DIV_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    clint_timer_if.slave bus,
    output logic         irq_timer
);

    localparam logic [15:0] OffCtrl   = 16'h0000;
    localparam logic [15:0] OffCmpLo  = 16'h4000;
    localparam logic [15:0] OffCmpHi  = 16'h4004;
    localparam logic [15:0] OffTimeLo = 16'hbff8;
    localparam logic [15:0] OffTimeHi = 16'hbffc;

    logic [63:0]      mtime_q, mtime_d;
    logic [63:0]      mtimecmp_q, mtimecmp_d;
    logic [DIV_W-1:0] pc_q, pc_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             en_q, en_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             irq_q, irq_d;

    logic        in_region, wr_en, rd_en;
    logic        ctrl_wr, tick;
    logic [31:0] ctrl_val, ctrl_new;
    logic [15:0] off;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] mk);
        logic [31:0] res;
        res = old;
        for (int i = 0; i < 4; i++) begin
            if (mk[i]) res[8*i +: 8] = wd[8*i +: 8];
        end
        return res;
    endfunction

    always_comb begin
        ctrl_val             = '0;
        ctrl_val[0]          = en_q;
        ctrl_val[8 +: DIV_W] = div_q;
    end

    assign off       = bus.mem_addr[15:0];
    assign in_region = bus.mem_valid && (bus.mem_addr[31:16] == BASE[31:16]);
    assign wr_en     = in_region && bus.mem_write;
    assign rd_en     = in_region && !bus.mem_write;
    assign ctrl_wr   = wr_en && (off == OffCtrl);
    assign ctrl_new  = merge(ctrl_val, bus.mem_wdata, bus.mem_wmask);
    // A CTRL write restarts the prescale phase, so it can never tick in the same cycle.
    assign tick      = en_q && !ctrl_wr && (pc_q == div_q);

    always_comb begin
        en_d       = en_q;
        div_d      = div_q;
        pc_d       = pc_q;
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        rdata_d    = rdata_q;
        irq_d      = (mtime_q >= mtimecmp_q);

        if (ctrl_wr || !en_q) begin
            pc_d = '0;
        end else if (pc_q == div_q) begin
            pc_d = '0;
        end else begin
            pc_d = pc_q + 1'b1;
        end

        if (tick) mtime_d = mtime_q + 64'd1;

        if (wr_en) begin
            case (off)
                OffCtrl: begin
                    en_d  = ctrl_new[0];
                    div_d = ctrl_new[8 +: DIV_W];
                end
                OffCmpLo:  mtimecmp_d[31:0]  = merge(mtimecmp_q[31:0], bus.mem_wdata,
                                                     bus.mem_wmask);
                OffCmpHi:  mtimecmp_d[63:32] = merge(mtimecmp_q[63:32], bus.mem_wdata,
                                                     bus.mem_wmask);
                // Software writes to mtime override the tick for the whole 64-bit value.
                OffTimeLo: mtime_d = {mtime_q[63:32],
                                      merge(mtime_q[31:0], bus.mem_wdata, bus.mem_wmask)};
                OffTimeHi: mtime_d = {merge(mtime_q[63:32], bus.mem_wdata, bus.mem_wmask),
                                      mtime_q[31:0]};
                default: ;
            endcase
        end

        if (rd_en) begin
            case (off)
                OffCtrl:   rdata_d = ctrl_val;
                OffCmpLo:  rdata_d = mtimecmp_q[31:0];
                OffCmpHi:  rdata_d = mtimecmp_q[63:32];
                OffTimeLo: rdata_d = mtime_q[31:0];
                OffTimeHi: rdata_d = mtime_q[63:32];
                default:   rdata_d = 32'hFFFF_FFFF;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            pc_q       <= '0;
            div_q      <= '0;
            en_q       <= 1'b1;
            rdata_q    <= '0;
            irq_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            pc_q       <= pc_d;
            div_q      <= div_d;
            en_q       <= en_d;
            rdata_q    <= rdata_d;
            irq_q      <= irq_d;
        end
    end

    assign bus.mem_rdata = rdata_q;
    assign irq_timer     = irq_q;

endmodule
